// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction RAM with a streaming load port and a one-cycle fetch handshake.
// Misaligned or out-of-program fetches return NOP_WORD and raise fault.
module instr_mem_loadable #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter int              DEPTH    = 128,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [DATA_W-1:0]           load_data,
    input  logic                        load_last,
    input  logic                        fetch_req,
    input  logic [ADDR_W-1:0]           pc,
    output logic                        fetch_ready,
    output logic [DATA_W-1:0]           instr,
    output logic                        instr_valid,
    output logic                        fault,
    output logic [$clog2(DEPTH):0]      prog_len,
    output logic                        loading
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    load_ptr_q, load_ptr_d;
    logic [LEN_W-1:0]    prog_len_q, prog_len_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                fault_q, fault_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;

    logic [ADDR_W-2:0]   word_idx;
    logic                accept;
    logic                bad_addr;

    assign word_idx = pc[ADDR_W-1:1];
    assign accept   = fetch_req && (state_q == ST_RUN);
    // Full-width compare so high PC bits fault instead of aliasing into the array.
    assign bad_addr = pc[0] || (ADDR_W'(word_idx) >= ADDR_W'(prog_len_q));

    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        prog_len_d    = prog_len_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_d       = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = load_ptr_q[IDX_W-1:0];

        if (load_start) begin
            // Restart wins over any word presented in the same cycle.
            state_d    = ST_LOAD;
            load_ptr_d = '0;
            prog_len_d = '0;
        end else if ((state_q == ST_LOAD) && load_valid) begin
            mem_we     = 1'b1;
            load_ptr_d = load_ptr_q + 1'b1;
            if (load_last || (load_ptr_q == LEN_W'(DEPTH - 1))) begin
                state_d    = ST_RUN;
                prog_len_d = load_ptr_q + 1'b1;
            end
        end

        if (accept) begin
            instr_valid_d = 1'b1;
            if (bad_addr) begin
                instr_d = NOP_WORD;
                fault_d = 1'b1;
            end else begin
                instr_d = mem[word_idx[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            load_ptr_q    <= '0;
            prog_len_q    <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            prog_len_q    <= prog_len_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    // Array is deliberately left out of reset; prog_len gates stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= load_data;
        end
    end

    assign fetch_ready = (state_q == ST_RUN);
    assign loading     = (state_q == ST_LOAD);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign prog_len    = prog_len_q;

endmodule
